// File: rtl/jk_pkg.sv
// Shared definitions for the JK counter bank: operating modes and the
// characteristic equation of a single JK flip-flop.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_CPL  = 2'b11
  } mode_t;

  // JK characteristic: 00 hold, 01 reset, 10 set, 11 toggle.
  function automatic logic jk_eval(input logic j, input logic k, input logic q);
    logic r;
    unique case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with asynchronous active-low reset to a per-cell value.
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  // State bit: reset value on rst_n low, JK characteristic on each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= jk_eval(j_i, k_i, q_q);
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit register made of JK cells. Every mode is reduced to a desired
// next value, which is then translated into J/K excitations for the cells;
// JK mode passes the user j/k straight through instead.
module jk_counter_bank
  import jk_pkg::*;
#(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 10,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Elaboration guards on the parameter space.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("jk_counter_bank: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("jk_counter_bank: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("jk_counter_bank: RESET_VAL must be below MODULUS");
  end

  // Largest legal count; MOD_X is one bit wider so 2**WIDTH is representable.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

  mode_t            mode_s;
  logic [WIDTH-1:0] next_d;
  logic             wrap_d;
  logic             wrap_q;
  logic             in_range;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;

  assign mode_s   = mode_t'(mode);
  assign in_range = ({1'b0, q} < MOD_X);

  // Desired next value and wrap indication for the counting modes.
  always_comb begin
    next_d = q;
    wrap_d = 1'b0;
    unique case (mode_s)
      MODE_JK: begin
        next_d = q;
      end
      MODE_UP: begin
        if (q >= MAX_Q) begin
          next_d = '0;
          wrap_d = 1'b1;
        end else begin
          next_d = q + WIDTH'(1);
        end
      end
      MODE_DOWN: begin
        if (q == '0) begin
          next_d = MAX_Q;
          wrap_d = 1'b1;
        end else if (in_range) begin
          next_d = q - WIDTH'(1);
        end else begin
          next_d = MAX_Q;
        end
      end
      MODE_CPL: begin
        next_d = ~q;
      end
    endcase
    if (load) begin
      next_d = d;
      wrap_d = 1'b0;
    end
    if (!en) begin
      wrap_d = 1'b0;
    end
  end

  // Cell excitation: hold when disabled, user j/k in JK mode, otherwise
  // set/reset only the bits that must change to reach next_d.
  always_comb begin
    cell_j = '0;
    cell_k = '0;
    if (en) begin
      if (!load && mode_s == MODE_JK) begin
        cell_j = j;
        cell_k = k;
      end else begin
        cell_j = next_d & ~q;
        cell_k = ~next_d & q;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST_VAL(RST_Q[i])
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .j_i  (cell_j[i]),
      .k_i  (cell_k[i]),
      .q_o  (q[i])
    );
  end

  // Wrap pulse register, one cycle after the wrapping edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

  // Combinational terminal count for cascading into the next stage's en.
  assign tc = en & ~load &
              (((mode_s == MODE_UP) && (q == MAX_Q)) ||
               ((mode_s == MODE_DOWN) && (q == '0)));

endmodule

// File: doc/jk_counter_bank.md
Name: jk_counter_bank

Overview:
- WIDTH-bit register built from an array of JK cells, the parametrised successor to the single-bit JK flip-flop.
- Selectable modes: per-bit JK control, modulo-MODULUS up count, modulo-MODULUS down count, and complement.
- Also supports synchronous parallel load, clock enable, terminal-count flag and a registered wrap pulse.
- Sits in lab datapaths as a general counter/register primitive, e.g. BCD digits, dividers and state registers.

Parameters:
- WIDTH, 4, register width in bits (1..32).
- MODULUS, 10, count modulus; legal range 2..2**WIDTH.
- RESET_VAL, 0, value of q after reset; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  clock enable for load and all modes.
- load  input  1  synchronous parallel load of d.
- mode  input  2  00 JK, 01 UP, 10 DOWN, 11 COMPLEMENT.
- d  input  WIDTH  parallel load data.
- j  input  WIDTH  per-bit J; used only in JK mode.
- k  input  WIDTH  per-bit K; used only in JK mode.
- q  output  WIDTH  register state.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse flagging a modulo wrap.

Behaviour:
- Reset: rst_n low forces q=RESET_VAL and wrap=0 immediately, independent of clk.
  - Asserting rst_n mid-count aborts the count; no pending wrap survives reset.
  - The first edge after rst_n rises behaves normally.
- Update priority on each rising clk edge: en=0 → hold (wrap=0); else load=1 → q=d; else mode.
- Load stores d unmodified, even when d ≥ MODULUS; wrap=0 on a load cycle.
- JK mode, per bit i:
  - j=0, k=0 → hold.
  - j=0, k=1 → 0.
  - j=1, k=0 → 1.
  - j=1, k=1 → toggle.
  - wrap=0.
- UP mode:
  - q < MODULUS-1 → q+1, wrap=0.
  - q ≥ MODULUS-1 → q=0, wrap=1 on the following cycle.
  - Out-of-range values therefore recover to 0.
- DOWN mode:
  - q == 0 → q=MODULUS-1, wrap=1.
  - 0 < q < MODULUS → q-1, wrap=0.
  - q ≥ MODULUS → q=MODULUS-1, wrap=0 (recovery, not a wrap).
- COMPLEMENT mode: q = ~q on all bits, no modulo clamp, wrap=0.
- wrap is a registered output: high exactly the one cycle after the wrapping edge, otherwise 0.
  - Back-to-back wraps are possible: MODULUS=2 with continuous UP gives wrap every other cycle.
- tc = en & ~load & ((mode==UP & q==MODULUS-1) | (mode==DOWN & q==0)).
  - tc is combinational, for cascading the en input of the next stage.
- Cell-based implementation requirement:
  - Compute next = f(mode, q, d, j, k).
  - Drive each cell with J=next&~q and K=~next&q, or with j/k directly in JK mode.
  - No behavioural shortcut may bypass the cells.
- Arithmetic is WIDTH bits, unsigned; MODULUS == 2**WIDTH behaves as a natural binary wrap.
- Illegal parameters (MODULUS < 2, MODULUS > 2**WIDTH, RESET_VAL ≥ MODULUS) trigger an elaboration-time error.

Decomposition:
- Package jk_pkg holds:
  - mode constants MODE_JK=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_CPL=2'b11;
  - a mode_t typedef.
- Sub-module jk_cell: one JK flip-flop with clk, rst_n, its reset value, j, k and q.
  - jk_counter_bank instantiates WIDTH cells in a generate loop.
  - Next-state and tc logic stay in the top module.

Test Plan:
- Reset: WIDTH=4, MODULUS=10, RESET_VAL=3; drop rst_n between edges → q=3 immediately, wrap=0; release → holds 3 with en=0.
- UP count: en=1, mode=UP from 0 for 12 edges → q runs 1..9,0,1,2; tc=1 while q=9; wrap=1 only in the cycle after the 9→0 edge.
- DOWN plus recovery: load d=13, then mode=DOWN → q=9 with no wrap, then 8..0, then 9 with a wrap pulse; tc=1 while q=0.
- JK mode: q=4'b0101, j=4'b1100, k=4'b1010 → q=4'b1101; repeat → q=4'b0101 (bit3 toggles, bit2 set, bit1 reset, bit0 hold).
- Priority: en=0 with load=1 → q holds; en=1, load=1, mode=UP, d=7 → q=7, wrap=0; mode=CPL → q=4'b1000.
- Cascade: two instances (units tc → tens en, MODULUS=10), 100 UP edges from 00 → returns to 00; tens wrap pulses once.
